// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 width codes, FSM
// state encoding and the access-legality check.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  // Stores only have b/h/w; unsigned codes are meaningless for them.
  function automatic logic lsu_err(input logic we, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic e;
    e = 1'b1;
    case (f3)
      F3_B:  e = 1'b0;
      F3_H:  e = lo[0];
      F3_W:  e = |lo;
      F3_BU: e = we;
      F3_HU: e = we | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte/half merge of
// store data into the previously read word for partial stores.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rword[7:0];
    case (addr_lo)
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      2'd3:    lane_b = rword[31:24];
      default: lane_b = rword[7:0];
    endcase
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = rword;
    endcase
  end

  always_comb begin
    merge_data = old_word;
    if (funct3 == F3_B) begin
      case (addr_lo)
        2'd0: merge_data[7:0]   = wdata[7:0];
        2'd1: merge_data[15:8]  = wdata[7:0];
        2'd2: merge_data[23:16] = wdata[7:0];
        2'd3: merge_data[31:24] = wdata[7:0];
        default: merge_data = old_word;
      endcase
    end else if (funct3 == F3_H) begin
      if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
      else            merge_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller over a word-wide memory with asynchronous read.
// Partial stores use read-modify-write through a merge register.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_MemRW,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  logic [1:0]  state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] merge_q, merge_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        err;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .rword      (mem_read_data),
    .wdata      (wdata_q),
    .old_word   (merge_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign err            = lsu_err(we_q, f3_q, addr_q[1:0]);
  assign req_ready      = (state_q == ST_IDLE);
  assign accept         = req_valid & req_ready;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_write_data = (state_q == ST_WRITE) ? merge_data : wdata_q;
  assign mem_MemRW      = ((state_q == ST_ACCESS) & we_q & (f3_q == F3_W) & ~err)
                        | (state_q == ST_WRITE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    merge_d      = merge_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (err) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = ST_IDLE;
        end else if (!we_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
          state_d      = ST_IDLE;
        end else if (f3_q == F3_W) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          merge_d = mem_read_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      merge_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      merge_q      <= merge_d;
    end
  end

  // Request fields are pure datapath; they are only consumed after acceptance.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural word memory and scoreboards
// for responses and write strobes.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_MemRW;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t rq[$];
  int   sq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_k = 0;
  int   last_lat = 0;
  exp_t mon_e;
  int   mon_s;

  lsu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_MemRW      (mem_MemRW),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_MemRW) mem[mem_addr[7:2]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Response and strobe scoreboards; cycle number of the current cycle is cyc+1.
  always @(negedge clk) begin
    if (mem_MemRW) begin
      if (sq.size() == 0) chk("unexpected_strobe", 32'(cyc + 1), 32'd0);
      else begin
        mon_s = sq.pop_front();
        chk("strobe_cycle", 32'(cyc + 1), 32'(mon_s));
      end
    end
    if (!rst && resp_valid) begin
      if (rq.size() == 0) chk("unexpected_resp", 32'(cyc + 1), 32'd0);
      else begin
        mon_e = rq.pop_front();
        chk("resp_cycle", 32'(cyc + 1), 32'(mon_e.cyc));
        chk("resp_rdata", resp_rdata, mon_e.rd);
        chk("resp_err", 32'(resp_err), 32'(mon_e.err));
      end
    end
  end

  // lat=0 / stb=0 mean no response / no strobe expected.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e,
                       input int lat, input int stb, input bit hold);
    int n;
    int k;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    k = cyc;
    if (lat > 0) begin
      e.rd = exp_rd; e.err = exp_e; e.cyc = k + lat;
      rq.push_back(e);
    end
    if (stb > 0) sq.push_back(k + stb);
    if (hold) chk("b2b_accept_edge", 32'(k), 32'(last_k + last_lat));
    last_k = k;
    last_lat = lat;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || sq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp", 32'(rq.size()), 32'd0);
    chk("drain_strobe", 32'(sq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_memrw", 32'(mem_MemRW), 32'd0);
    rst = 1'b0;

    // Loads from word 0x10.
    issue(1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 1'b0); drain();
    issue(1'b0, 3'd4, 32'h12, 32'h0, 32'h00000099, 1'b0, 2, 0, 1'b0); drain();
    issue(1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, 1'b0); drain();
    issue(1'b0, 3'd5, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0, 1'b0); drain();
    issue(1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 1'b0); drain();

    // Partial and full stores.
    issue(1'b1, 3'd0, 32'h11, 32'h00000055, 32'h0, 1'b0, 3, 2, 1'b0); drain();
    chk("mem_after_sb", mem[4], 32'h889955BB);
    issue(1'b1, 3'd2, 32'h10, 32'h12345678, 32'h0, 1'b0, 2, 1, 1'b0); drain();
    chk("mem_after_sw", mem[4], 32'h12345678);
    issue(1'b1, 3'd1, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, 3, 2, 1'b0); drain();
    chk("mem_after_sh", mem[4], 32'hABCD5678);

    // Misaligned and illegal accesses.
    issue(1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1, 2, 0, 1'b0); drain();
    issue(1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 0, 1'b0); drain();
    issue(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0, 1'b0); drain();
    issue(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 0, 1'b0); drain();
    chk("mem_after_errs", mem[4], 32'hABCD5678);

    // Reset while the sh is in WRITE.
    issue(1'b1, 3'd1, 32'h10, 32'h0000FFFF, 32'h0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_memrw", 32'(mem_MemRW), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();
    chk("mem_after_abort", mem[4], 32'hABCD5678);

    // Back-to-back: each next request accepted in the previous response cycle.
    issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hABCD5678, 1'b0, 2, 0, 1'b0);
    issue(1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 1'b1);
    issue(1'b0, 3'd0, 32'h17, 32'h0, 32'hFFFFFFCA, 1'b0, 2, 0, 1'b1);
    drain();
    chk("mem_after_b2b", mem[5], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  core presents a load/store request.
REQ-004 SHALL have: req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-005 SHALL have: req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have: req_funct3  in  3  RV32I width/sign code: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-007 SHALL have: req_addr  in  32  byte address.
REQ-008 SHALL have: req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have: resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-011 SHALL have: resp_err  out  1  misaligned or illegal funct3, valid with resp_valid.
REQ-012 SHALL have: mem_MemRW  out  1  word-write strobe to data memory.
REQ-013 SHALL have: mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 SHALL have: mem_write_data  out  32  full word to write.
REQ-015 SHALL have: mem_read_data  in  32  asynchronous word read of mem_addr.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, WRITE; acceptance in IDLE latches we/funct3/addr/wdata and moves to ACCESS.
REQ-017 Load in ACCESS: mem_MemRW=0; the extracted byte/half/word, sign- or zero-extended per funct3, SHALL be registered into resp_rdata; next state IDLE with resp_valid=1.
REQ-018 Load latency SHALL be 2 cycles: accept at edge k, resp_valid high during cycle k+2.
REQ-019 sw in ACCESS: mem_MemRW=1, mem_write_data=wdata; next IDLE with resp_valid; latency 2.
REQ-020 sb/sh in ACCESS: mem_MemRW=0, old word captured into a merge register; WRITE: mem_MemRW=1, data = old word with lane addr[1:0] (b) or addr[1] (h) replaced; then IDLE with resp_valid; latency 3.
REQ-021 Misaligned (w with addr[1:0]!=0; h/hu with addr[0]=1) or illegal funct3 (loads 3/6/7, stores >2) SHALL pass through ACCESS with mem_MemRW=0, then resp_valid=1, resp_err=1, resp_rdata=0; latency 2.
REQ-022 mem_MemRW SHALL be 1 only in ACCESS for a legal sw and in WRITE; exactly one strobe cycle per legal store.
REQ-023 A new request SHALL be acceptable in the same cycle resp_valid is high (back-to-back, no bubble beyond latency).
REQ-024 resp_valid, resp_err SHALL be registered and deasserted in all cycles except the completion cycle.
REQ-025 req_addr/req_wdata changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-026 On rst: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_MemRW=0, merge register 0.
REQ-027 Reset in ACCESS or WRITE SHALL abort the operation with no mem_MemRW strobe and no resp_valid.

Structure
REQ-028 A shared package SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding.
REQ-029 Lane extraction/extension and store merge SHALL live in one combinational sub-module lsu_align.

Verification
REQ-030 Word 0x10 = 0x8899AABB; lb 0x13 -> resp_rdata 0xFFFFFF88; lbu 0x12 -> 0x00000099; lh 0x10 -> 0xFFFFAABB; each at latency 2.
REQ-031 sb 0x11 wdata 0x00000055 -> one MemRW pulse at cycle k+2, word becomes 0x889955BB, resp_valid at k+3.
REQ-032 sw 0x10 wdata 0x12345678 -> MemRW at k+1 only, word 0x12345678, resp_valid at k+2, resp_err 0.
REQ-033 lw 0x12 and sh 0x11 -> resp_err=1, resp_rdata=0, no MemRW, memory unchanged.
REQ-034 rst asserted during WRITE of sh 0x10 -> no MemRW, no resp_valid, req_ready=1 after reset, memory unchanged.
REQ-035 Back-to-back lw, sw, lb with req_valid held -> each accepted in its response cycle, results correct in order.
